// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the snake datapath: IDLE/PLAY/OVER sequencing,
// frame-paced stepping, direction filtering, collision resolution and apple handshake.
module snake_game_ctrl #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int MAX_LEN         = 128,
  parameter int FLASH_FRAMES    = 30
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_end,
  input  logic       hit_apple,
  input  logic       hit_lethal,
  input  logic [3:0] dir_btn,
  input  logic       apple_ack,
  output logic       init,
  output logic       step,
  output logic       grow,
  output logic [1:0] dir,
  output logic       apple_req,
  output logic [6:0] length,
  output logic [7:0] score,
  output logic       game_over,
  output logic [7:0] led,
  output logic [1:0] state
);

  // Handshake: apple_req is a level held from the apple evaluation until the
  // cycle after apple_ack is sampled high; an ack while apple_req=0 is ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int           FW         = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [5:0]   STEP_LAST  = 6'(FRAMES_PER_STEP - 1);
  localparam logic [6:0]   LEN_SAT    = 7'(MAX_LEN - 1);

  state_t cur_state, nxt_state;

  logic          start_d;
  logic          start_block;
  logic          apple_seen;
  logic          lethal_seen;
  logic          grow_pend;
  logic [1:0]    next_dir;
  logic [5:0]    frame_cnt;
  logic [FW-1:0] flash_cnt;

  logic          init_d, step_d, grow_d, apple_req_d, game_over_d;
  logic [1:0]    dir_d, next_dir_d;
  logic [6:0]    length_d;
  logic [7:0]    score_d, led_d;
  logic          start_block_d, apple_seen_d, lethal_seen_d, grow_pend_d;
  logic [5:0]    frame_cnt_d;
  logic [FW-1:0] flash_cnt_d;

  logic          in_play, start_go, start_rise;
  logic          lethal_eval, eat, step_fire;
  logic          btn_valid, btn_accept;
  logic [1:0]    btn_code;

  assign in_play     = (cur_state == S_PLAY);
  assign start_go    = (cur_state == S_IDLE) && start && !start_block;
  assign start_rise  = start && !start_d;
  assign lethal_eval = in_play && frame_end && (lethal_seen || hit_lethal);
  assign eat         = in_play && frame_end && !lethal_eval && !apple_req &&
                       (apple_seen || hit_apple);
  assign step_fire   = in_play && frame_end && !lethal_eval && (frame_cnt == STEP_LAST);
  assign state       = cur_state;

  always_comb begin
    btn_valid = 1'b1;
    btn_code  = 2'd0;
    case (dir_btn)
      4'b0001: btn_code  = 2'd0;
      4'b0010: btn_code  = 2'd1;
      4'b0100: btn_code  = 2'd2;
      4'b1000: btn_code  = 2'd3;
      default: btn_valid = 1'b0;
    endcase
  end

  // Opposite directions differ only in bit 0 (left/right, down/up).
  assign btn_accept = btn_valid && (btn_code != (dir ^ 2'd1));

  always_ff @(posedge VGA_clk) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:  if (start_go)    nxt_state = S_PLAY;
      S_PLAY:  if (lethal_eval) nxt_state = S_OVER;
      S_OVER:  if (start_rise)  nxt_state = S_IDLE;
      default:                  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    init_d        = start_go;
    step_d        = step_fire;
    // An apple eaten in the stepping frame itself grows on that same step.
    grow_d        = step_fire && (grow_pend || eat) && (length != LEN_SAT);
    dir_d         = dir;
    next_dir_d    = next_dir;
    length_d      = length;
    score_d       = score;
    apple_req_d   = apple_req;
    grow_pend_d   = grow_pend;
    frame_cnt_d   = frame_cnt;
    apple_seen_d  = 1'b0;
    lethal_seen_d = 1'b0;
    game_over_d   = (nxt_state == S_OVER);
    led_d         = 8'h00;
    flash_cnt_d   = '0;
    start_block_d = start_block;

    if (btn_accept)     next_dir_d = btn_code;
    if (step_fire)      dir_d      = next_dir;
    if (grow_d)         length_d   = length + 7'd1;
    if (step_fire)      grow_pend_d = 1'b0;
    else if (eat)       grow_pend_d = 1'b1;
    if (eat && score != 8'hFF) score_d = score + 8'd1;

    if (eat)            apple_req_d = 1'b1;
    else if (apple_ack) apple_req_d = 1'b0;

    if (in_play && frame_end) begin
      frame_cnt_d = (frame_cnt == STEP_LAST) ? 6'd0 : frame_cnt + 6'd1;
    end

    if (in_play && !frame_end) begin
      apple_seen_d  = apple_seen || (hit_apple && !apple_req);
      lethal_seen_d = lethal_seen || hit_lethal;
    end

    if (start_go) begin
      dir_d       = 2'd1;
      next_dir_d  = 2'd1;
      length_d    = 7'd1;
      score_d     = 8'd0;
      apple_req_d = 1'b1;
      grow_pend_d = 1'b0;
      frame_cnt_d = 6'd0;
    end

    if (cur_state != S_OVER && nxt_state == S_OVER) begin
      led_d = 8'hFF;
    end else if (cur_state == S_OVER && nxt_state == S_OVER) begin
      led_d       = led;
      flash_cnt_d = flash_cnt;
      if (frame_end) begin
        if (flash_cnt == FLASH_LAST) begin
          flash_cnt_d = '0;
          led_d       = ~led;
        end else begin
          flash_cnt_d = flash_cnt + 1'b1;
        end
      end
    end

    // A start that ends the game must be released before it can begin a new one.
    if (cur_state == S_OVER && start_rise) start_block_d = 1'b1;
    else if (!start)                       start_block_d = 1'b0;
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      init        <= 1'b0;
      step        <= 1'b0;
      grow        <= 1'b0;
      dir         <= 2'd1;
      next_dir    <= 2'd1;
      apple_req   <= 1'b0;
      length      <= 7'd1;
      score       <= 8'd0;
      game_over   <= 1'b0;
      led         <= 8'h00;
      start_d     <= 1'b0;
      start_block <= 1'b0;
      apple_seen  <= 1'b0;
      lethal_seen <= 1'b0;
      grow_pend   <= 1'b0;
      frame_cnt   <= 6'd0;
      flash_cnt   <= '0;
    end else begin
      init        <= init_d;
      step        <= step_d;
      grow        <= grow_d;
      dir         <= dir_d;
      next_dir    <= next_dir_d;
      apple_req   <= apple_req_d;
      length      <= length_d;
      score       <= score_d;
      game_over   <= game_over_d;
      led         <= led_d;
      start_d     <= start;
      start_block <= start_block_d;
      apple_seen  <= apple_seen_d;
      lethal_seen <= lethal_seen_d;
      grow_pend   <= grow_pend_d;
      frame_cnt   <= frame_cnt_d;
      flash_cnt   <= flash_cnt_d;
    end
  end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-flow controller that sequences the snake datapath. It owns the run/over state machine, paces snake movement in whole video frames, and filters the direction buttons. It also resolves head collisions reported by the pixel-scan logic, and runs the request/acknowledge handshake with the apple placer. It sits between the VGA timing generator, the collision detectors and the snake body shift register, and drives the game-over LEDs.

## Interface
- FRAMES_PER_STEP, 6: video frames between snake moves (1..63)
- MAX_LEN, 128: maximum snake segments, including the head
- FLASH_FRAMES, 30: frames per LED toggle in OVER
- VGA_clk  in  1  pixel clock; everything is in this domain
- reset  in  1  synchronous, active-high; clock VGA_clk
- start  in  1  debounced start button, level
- frame_end  in  1  one-cycle pulse at end of visible area, once per frame
- hit_apple  in  1  head overlaps apple this pixel
- hit_lethal  in  1  head overlaps border or body this pixel
- dir_btn  in  4  one-hot {up,down,right,left} = bits [3:0]
- apple_ack  in  1  apple placer has loaded new coordinates
- init  out  1  one-cycle pulse: reload snake to start position
- step  out  1  one-cycle pulse: shift body, move head one cell
- grow  out  1  one-cycle pulse, coincident with step: keep tail
- dir  out  2  0=left 1=right 2=down 3=up, valid with step
- apple_req  out  1  level, request new apple position
- length  out  7  current segment count, i.e. length-1 is the body count; MAX_LEN=128 encoded as 127 saturation
- score  out  8  apples eaten, saturating at 255
- game_over  out  1  high in OVER
- led  out  8  all-on or all-off flash pattern
- state  out  2  IDLE=0 PLAY=1 OVER=2

## Operation
- FSM transitions:
  - IDLE → PLAY on start=1. This issues init for 1 cycle, raises apple_req, and sets length=1, score=0, dir=right, frame count=0.
  - PLAY → OVER on a lethal evaluation (see below).
  - OVER → IDLE on a start rising edge. Holding start from OVER does not re-enter PLAY directly.
- Collision accumulation in PLAY:
  - Flags apple_seen and lethal_seen set on any cycle with hit_apple or hit_lethal.
  - At a frame_end cycle, evaluation uses (flag OR same-cycle input), then clears both flags.
  - Flags are cleared in IDLE and OVER.
- Evaluation priority:
  - Lethal beats apple in the same frame; score and length stay unchanged.
  - Apple hits are ignored while apple_req=1, since the apple is being repositioned.
- Apple eaten:
  - score +1 (saturate), apple_req=1.
  - A grow flag is pending; it is consumed by the next step, which asserts grow and length +1 (saturating at MAX_LEN-1 encoding; grow suppressed at saturation).
- apple_req is held high until apple_ack=1 is sampled. It clears the cycle after ack. An ack with no request is ignored.
- Direction filter:
  - A dir_btn value with exactly one bit set is latched as next_dir.
  - Zero or multi-bit values are ignored.
  - A request opposite to the currently committed dir (left/right, up/down) is discarded.
  - next_dir is committed to dir only at step.
- Frame pacing:
  - A 6-bit frame counter increments on each frame_end in PLAY.
  - When it reaches FRAMES_PER_STEP-1 with no lethal evaluation, it wraps to 0 and step fires.
- LEDs:
  - In OVER, a frame counter toggles led between 8'hFF and 8'h00 every FLASH_FRAMES frames, starting with 8'hFF on OVER entry.
  - led=0 in all other states.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, init=0, step=0, grow=0, dir=1, apple_req=0, length=1, score=0, game_over=0, led=0.
- step, grow and the committed dir appear 1 cycle after the qualifying frame_end.
- game_over and state=OVER appear 1 cycle after the lethal frame_end. No step is issued in that frame.
- init appears 1 cycle after start is sampled in IDLE.
- score updates 1 cycle after the evaluating frame_end.
- apple_req:
  - rises 1 cycle after an apple evaluation;
  - falls 1 cycle after ack;
  - ack and a new apple event in the same cycle: the request stays high.
- reset mid-game: everything returns to reset values on the next edge, including the pending grow and flags.

## Test plan
- Reset, start=1 one cycle → init pulse at +1, state=PLAY, apple_req=1; apple_ack at cycle 10 → apple_req=0 at cycle 11.
- PLAY, 12 frame_end pulses with no hits, FRAMES_PER_STEP=6 → exactly 2 step pulses, each 1 cycle after the 6th and 12th frame_end, dir=1.
- hit_apple mid-frame (apple_req=0) → score=1 after frame_end; next step carries grow=1, length 1→2; a second hit_apple before ack → ignored, score stays 1.
- hit_apple and hit_lethal in same frame → state=OVER, game_over=1, score unchanged, no step; led=FF then 00 after 30 frames.
- dir=right, dir_btn=left → ignored; dir_btn=4'b0011 → ignored; dir_btn=up → dir=3 at next step.
- Reset asserted during PLAY with pending grow → all outputs at reset values next cycle; a later start gives length=1.
